// File: rtl/clk_seq_pkg.sv
//============================================================
// clk_seq_pkg : state encodings and constants for clk_seq_gen
// Rev 1.0
//============================================================
`default_nettype none

package clk_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABILIZE = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_e;

  localparam int LOSS_CNT_W = 8;
  localparam int SYNC_DEPTH = 2;

endpackage

`default_nettype wire

// File: rtl/clk_en_div.sv
//============================================================
// clk_en_div : one clock-enable channel (down-counter, shadow divisor, ce reg)
// Rev 1.0
//============================================================
`default_nettype none

module clk_en_div #(
  parameter int DIV_W = 8
) (
  input  logic             clock_in,
  input  logic             resetn,
  input  logic             run_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             ce_o
);

  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ce_q, ce_d;

  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  // Reload uses the pre-load shadow so a load landing on a ce edge waits one period.
  always_comb begin
    shadow_d = load_i ? div_i : shadow_q;
    cnt_d    = cnt_q;
    ce_d     = 1'b0;
    if (!run_i) begin
      cnt_d = eff_div(shadow_d) - DIV_W'(1);
    end else if (cnt_q == '0) begin
      ce_d  = 1'b1;
      cnt_d = eff_div(shadow_q) - DIV_W'(1);
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      shadow_q <= DIV_W'(1);
      cnt_q    <= '0;
      ce_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      ce_q     <= ce_d;
    end
  end

  assign ce_o = ce_q;

endmodule

`default_nettype wire

// File: rtl/clk_seq_gen.sv
//============================================================
// clk_seq_gen : PLL lock qualification, sequenced reset and ce strobes.
// Optional lock-loss counter built when CLKGEN_LOSS_CNT_EN is defined. Rev 1.0
//============================================================
`default_nettype none

module clk_seq_gen
  import clk_seq_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_STABLE = 1024,
  parameter int RST_HOLD    = 16
) (
  input  logic                    clock_in,
  input  logic                    resetn,
  input  logic                    locked,
  input  logic [NUM_CH*DIV_W-1:0] divisors,
  input  logic                    div_load,
  output logic                    sys_resetn,
  output logic [NUM_CH-1:0]       ce,
  output logic [1:0]              state,
  output logic [LOSS_CNT_W-1:0]   lock_loss_count
);

  localparam int CNT_MAX = (LOCK_STABLE > RST_HOLD) ? LOCK_STABLE : RST_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  lock_s;
  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sys_resetn_q;
  logic                  run_d;

  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_DEPTH-2:0], locked};
  end

  assign lock_s = sync_q[SYNC_DEPTH-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = ST_STABILIZE;
      end
      ST_STABILIZE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) state_d = ST_WAIT_LOCK;
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= '0;
      sys_resetn_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sys_resetn_q <= (state_d == ST_RUN);
    end
  end

  // Channels look at the next state so ce and sys_resetn change on the same edge.
  assign run_d = (state_d == ST_RUN);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_en_div #(
      .DIV_W (DIV_W)
    ) u_div (
      .clock_in (clock_in),
      .resetn   (resetn),
      .run_i    (run_d),
      .load_i   (div_load),
      .div_i    (divisors[k*DIV_W +: DIV_W]),
      .ce_o     (ce[k])
    );
  end

`ifdef CLKGEN_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (state_q == ST_RUN && !lock_s && loss_q != '1) loss_d = loss_q + LOSS_CNT_W'(1);
  end

  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) loss_q <= '0;
    else         loss_q <= loss_d;
  end

  assign lock_loss_count = loss_q;
`else
  assign lock_loss_count = '0;
`endif

  assign sys_resetn = sys_resetn_q;
  assign state      = state_q;

endmodule

`default_nettype wire

// File: doc/clk_seq_gen.md
# clk_seq_gen

Parametrised clock-sequencing block on the PLL output clock domain. It qualifies the PLL lock and releases a synchronous system reset only after lock has been continuously stable. It generates NUM_CH phase-aligned clock-enable strobes (e.g. 6502 CPU enable, VGA pixel enable) with runtime-loadable divisors. It replaces the bare lock output with a sequenced, loss-of-lock-aware reset and enable source.

## Interface
- NUM_CH, 2: number of clock-enable channels (1..4)
- DIV_W, 8: divisor width per channel
- LOCK_STABLE, 1024: cycles of continuous lock required before the hold phase
- RST_HOLD, 16: extra cycles sys_resetn stays low after lock qualifies

Ports:
- clock_in  in  1  PLL global clock; sole clock
- resetn  in  1  asynchronous active-low reset
- locked  in  1  PLL lock, asynchronous to clock_in
- divisors  in  NUM_CH*DIV_W  channel k divisor in bits [k*DIV_W +: DIV_W]
- div_load  in  1  one-cycle pulse; captures divisors into shadow registers
- sys_resetn  out  1  registered synchronous reset for the rest of the design; 0 until RUN
- ce  out  NUM_CH  registered one-cycle enable strobes
- state  out  2  current FSM state (debug)
- lock_loss_count  out  8  saturating count of lock drops while in RUN

## Operation
- `locked` passes through a 2-flop synchronizer (lock_s) before any use.
- FSM states:
  - WAIT_LOCK=0: leave when lock_s=1.
  - STABILIZE=1: count cycles with lock_s=1; on reaching LOCK_STABLE, go to HOLD. lock_s=0 clears the counter and returns to WAIT_LOCK.
  - HOLD=2: count RST_HOLD cycles, then go to RUN. lock_s=0 returns to WAIT_LOCK.
  - RUN=3: sys_resetn=1 and channels run. lock_s=0 drives sys_resetn=0 and ce=0 on the next edge, increments lock_loss_count (saturates at 255), and returns to WAIT_LOCK.
- Divisor D_eff = max(D,1). In RUN, channel k pulses ce[k] for one cycle every D_eff cycles.
  - All channels are reset-aligned on RUN entry. The first pulse is on RUN cycle D_eff, where cycle 1 is the first cycle sys_resetn=1.
  - D_eff=1 gives ce held high every RUN cycle.
- div_load updates the shadow registers on the next edge.
  - Outside RUN: the shadow is used directly at RUN entry.
  - In RUN: each channel adopts its shadow value only at its own ce cycle, so no period is truncated or stretched mid-count.
  - div_load coinciding with a ce: the new value takes effect at the following ce.
- Outside RUN, ce=0 and the counters are held at their alignment value.
- resetn=0 at any time: state=WAIT_LOCK, sys_resetn=0, ce=0, counters=0, lock_loss_count=0. Shadow divisors reset to 1.

## Timing
- Reset values: sys_resetn=0, ce=0, state=0, lock_loss_count=0.
- Lock qualification latency: with `locked` constant 1 from the edge it is first sampled, sys_resetn rises 2+LOCK_STABLE+RST_HOLD edges later (±1 edge for synchronizer metastability).
- Loss of lock: sys_resetn falls 3 edges after `locked` falls (2 synchronizer edges + 1 register edge). ce goes low on the same edge.
- A lock glitch shorter than the synchronizer window is filtered only if it is not sampled. Any sampled low restarts qualification from WAIT_LOCK.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- CLKGEN_LOSS_CNT_EN defined: the saturating lock_loss_count counter is built.
- CLKGEN_LOSS_CNT_EN undefined: lock_loss_count is tied to 0 and the counter logic is absent. FSM behaviour is otherwise identical.

## Structure
- Package clk_seq_pkg holds:
  - FSM state encodings ST_WAIT_LOCK..ST_RUN
  - the lock_loss_count width constant
  - the synchronizer depth constant (2)
- One sub-module, clk_en_div: a single channel holding its down-counter, shadow adoption and ce register. It is instantiated NUM_CH times via generate.

## Test plan
Bench parameters: LOCK_STABLE=8, RST_HOLD=4, NUM_CH=2.
- Lock at edge 0 and held -> sys_resetn rises at edge 14 (±1); state sequence 0,1,2,3.
- Lock drops for 3 cycles during STABILIZE -> returns to WAIT_LOCK; after lock returns, the full 14-edge qualification restarts; lock_loss_count stays 0.
- In RUN with divisors {3,1} -> ce[1] is high every cycle; ce[0] pulses on RUN cycles 3, 6, 9.
- In RUN with ch0 D=4, pulse div_load with D=2 two cycles after a ce -> the current period completes at 4, then period becomes 2.
- Lock drop in RUN, repeated 260 times -> sys_resetn and ce low 3 edges after each drop; lock_loss_count saturates at 255 (0 with macro undefined).
- Assert resetn=0 mid-RUN -> all outputs return to reset values asynchronously; qualification restarts after resetn=1.
